program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Fetch-address generator directly upstream of the instruction memory; PCaddress drives the memory's byte-address input.
- Holds the PC register and selects the next PC: sequential, branch, JAL or JALR.
- Handles stall, halt and resume.
- Traps on misaligned or out-of-range targets and keeps a retired-instruction counter for debug.

Parameters:
- RESET_ADDR, 32'h0000_0000: PC value after reset.
- TRAP_ADDR, 32'h0000_0FF0: PC value while in TRAP. Word-aligned and below MEM_BYTES.
- MEM_BYTES, 4096: instruction memory size in bytes (1024 words). Any target >= MEM_BYTES is out of range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCstall  in  1  hold PC this cycle (RUN only).
- PCbrTaken  in  1  conditional branch taken; target = PC+PCimm.
- PCjal  in  1  JAL; target = PC+PCimm.
- PCjalr  in  1  JALR; target = (PCrs1+PCimm) & ~32'h1.
- PCimm  in  32  sign-extended immediate from the decoder.
- PCrs1  in  32  rs1 value from the register file.
- PChalt  in  1  halt request.
- PCresume  in  1  leave HALT or TRAP.
- PCaddress  out  32  current PC; feeds instruction memory.
- PCplus4  out  32  PCaddress+4, combinational; JAL/JALR link value.
- PCstate  out  2  00 RUN, 01 HALT, 10 TRAP.
- PCcause  out  2  trap cause: 00 none, 01 misaligned, 10 out of range.
- PCepc  out  32  PC of the instruction that caused the last trap.
- PCcount  out  32  retired-instruction counter.

Behaviour:
- **Reset** (async, rst=1, takes effect immediately):
  - PCaddress=RESET_ADDR, PCstate=RUN, PCcause=00, PCepc=0, PCcount=0.
  - Deassertion takes effect at the next rising edge.
- **Next-target selection** (combinational, RUN only):
  - Priority: PCjalr > PCjal > PCbrTaken > PC+4.
  - All adds are 32-bit modulo 2^32; overflow wraps and is then range-checked.
- **Target check:**
  - target[1:0]!=00 → misaligned, cause 01.
  - Otherwise target >= MEM_BYTES → out of range, cause 10.
  - Misaligned has priority over out of range.
  - The sequential PC+4 is checked too: falling off the end of memory traps with cause 10.
  - JALR bit-0 clear is applied before the check.
- **RUN**, per rising edge, in priority order:
  1. PChalt=1 → PCstate=HALT; PC and PCcount unchanged.
  2. PCstall=1 → PC and PCcount unchanged; redirect inputs ignored.
  3. Target invalid → PCstate=TRAP, PCepc=PCaddress, PCcause=cause, PCaddress=TRAP_ADDR; PCcount unchanged.
  4. Otherwise → PCaddress=target, PCcount+=1, saturating at 32'hFFFF_FFFF.
- **HALT:**
  - PC and PCcount frozen; PCstall, redirect inputs and PChalt ignored.
  - PCresume=1 → RUN at the next edge, PC unchanged. No cycle lost beyond the resume edge.
- **TRAP:**
  - PCaddress held at TRAP_ADDR; PCcause and PCepc held.
  - PCresume=1 → RUN, PCaddress=PCepc+4, PCcause=00, PCepc retained.
  - If PCepc+4 >= MEM_BYTES: remain in TRAP with PCcause=10 and PCepc unchanged.
- PCresume in RUN is ignored. PCresume and PChalt together in HALT or TRAP: resume wins.
- Latency: redirect is one cycle. Controls sampled at edge n appear on PCaddress after edge n.
- Redirect inputs are qualified only in RUN with PCstall=0 and PChalt=0. Several asserted together resolve by priority with no error.
- Reset mid-stall, mid-halt or mid-trap returns everything to reset values asynchronously.

Test Plan:
1. Reset, then 5 edges with no controls → PCaddress 0,4,8,12,16,20; PCcount=5; PCplus4=24; PCstate=00.
2. At PC=0x10: PCimm=0xFFFF_FFF8 with PCbrTaken=1 → PC=0x08. Then PCjal=1 and PCjalr=1 together with PCrs1=0x101, PCimm=0x0F → PC=0x110 (JALR wins, bit0 cleared).
3. At PC=0x20: PCjal=1, PCimm=2 → PCstate=10, PCcause=01, PCepc=0x20, PCaddress=0xFF0. Then PCresume=1 → PCstate=00, PCaddress=0x24, PCcause=00.
4. At PC=0xFFC with no controls → TRAP with PCcause=10, PCepc=0xFFC. Then PCresume=1 → stays TRAP (0xFFC+4 out of range).
5. PCstall=1 with PCbrTaken=1 for 3 cycles at PC=0x40 → PC stays 0x40, PCcount unchanged. Then PChalt=1 together with PCstall=1 → HALT, PC=0x40. Then PCresume=1 → RUN, then PC=0x44.
6. Assert rst asynchronously between edges while in TRAP with PCcount=7 → immediately PCaddress=RESET_ADDR, PCstate=00, PCcause=00, PCepc=0, PCcount=0.

Source files
------------

// File: rtl/program_counter.sv
// program_counter: fetch-address generator with next-PC select, stall/halt/resume,
// alignment/range trapping and a saturating retired-instruction counter.
module program_counter #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0FF0,
  parameter int unsigned MEM_BYTES  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCstall,
  input  logic        PCbrTaken,
  input  logic        PCjal,
  input  logic        PCjalr,
  input  logic [31:0] PCimm,
  input  logic [31:0] PCrs1,
  input  logic        PChalt,
  input  logic        PCresume,
  output logic [31:0] PCaddress,
  output logic [31:0] PCplus4,
  output logic [1:0]  PCstate,
  output logic [1:0]  PCcause,
  output logic [31:0] PCepc,
  output logic [31:0] PCcount
);
  localparam logic [31:0] MEM_LIM = 32'(MEM_BYTES);
  typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, TRAP = 2'b10} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, epc_q, epc_d, count_q, count_d, tgt, resume_pc;
  logic [1:0]  cause_q, cause_d, tcause;
  always_comb begin
    tgt       = PCjalr ? ((PCrs1 + PCimm) & ~32'h1) : (PCjal || PCbrTaken) ? pc_q + PCimm : pc_q + 32'd4;
    tcause    = (tgt[1:0] != 2'b00) ? 2'b01 : (tgt >= MEM_LIM) ? 2'b10 : 2'b00;
    resume_pc = epc_q + 32'd4;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR;
      cause_q <= 2'b00;
      epc_q   <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    count_d = count_q;
    if (state_q == RUN) begin
      if (PChalt) state_d = HALT;
      else if (!PCstall) begin
        if (tcause != 2'b00) begin
          state_d = TRAP;
          epc_d   = pc_q;
          cause_d = tcause;
          pc_d    = TRAP_ADDR;
        end else begin
          pc_d    = tgt;
          count_d = count_q + {31'd0, ~&count_q};
        end
      end
    end else if (PCresume) begin
      // a resume whose return address would fall off memory re-traps in place
      if (state_q == HALT) state_d = RUN;
      else if (resume_pc >= MEM_LIM) cause_d = 2'b10;
      else begin
        state_d = RUN;
        pc_d    = resume_pc;
        cause_d = 2'b00;
      end
    end
  end
  always_comb begin
    PCaddress = pc_q;
    PCplus4   = pc_q + 32'd4;
    PCstate   = state_q;
    PCcause   = cause_q;
    PCepc     = epc_q;
    PCcount   = count_q;
  end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_program_counter;
  localparam longint MEM = 4096;
  localparam longint WRAP = 64'h1_0000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic PCstall, PCbrTaken, PCjal, PCjalr, PChalt, PCresume;
  logic [31:0] PCimm, PCrs1;
  logic [31:0] PCaddress, PCplus4, PCepc, PCcount;
  logic [1:0]  PCstate, PCcause;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_pc, m_epc, m_count;
  int m_state, m_cause;

  program_counter dut (
    .clk(clk), .rst(rst), .PCstall(PCstall), .PCbrTaken(PCbrTaken), .PCjal(PCjal),
    .PCjalr(PCjalr), .PCimm(PCimm), .PCrs1(PCrs1), .PChalt(PChalt), .PCresume(PCresume),
    .PCaddress(PCaddress), .PCplus4(PCplus4), .PCstate(PCstate), .PCcause(PCcause),
    .PCepc(PCepc), .PCcount(PCcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: state 0 RUN, 1 HALT, 2 TRAP; targets computed in 64-bit and reduced mod 2^32.
  always @(posedge clk or posedge rst) begin : model
    longint t;
    int c;
    if (rst) begin
      m_pc <= 0; m_state <= 0; m_cause <= 0; m_epc <= 0; m_count <= 0;
    end else if (m_state == 0) begin
      if (PChalt) m_state <= 1;
      else if (!PCstall) begin
        if (PCjalr) begin
          t = (longint'(PCrs1) + longint'(PCimm)) % WRAP;
          t = t - t % 2;
        end else if (PCjal || PCbrTaken) t = (longint'(m_pc) + longint'(PCimm)) % WRAP;
        else t = (longint'(m_pc) + 4) % WRAP;
        c = (t % 4 != 0) ? 1 : (t >= MEM) ? 2 : 0;
        if (c != 0) begin
          m_state <= 2; m_epc <= m_pc; m_cause <= c; m_pc <= 32'h0FF0;
        end else begin
          m_pc <= 32'(t);
          if (m_count != 32'hFFFF_FFFF) m_count <= m_count + 1;
        end
      end
    end else if (PCresume) begin
      if (m_state == 1) m_state <= 0;
      else if (longint'(m_epc) + 4 >= MEM) m_cause <= 2;
      else begin
        m_state <= 0; m_pc <= m_epc + 4; m_cause <= 0;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("cyc_pc", PCaddress, m_pc);
    chk("cyc_plus4", PCplus4, m_pc + 32'd4);
    chk("cyc_state", {30'd0, PCstate}, 32'(m_state));
    chk("cyc_cause", {30'd0, PCcause}, 32'(m_cause));
    chk("cyc_epc", PCepc, m_epc);
    chk("cyc_count", PCcount, m_count);
  end

  task automatic clr();
    PCstall = 0; PCbrTaken = 0; PCjal = 0; PCjalr = 0; PChalt = 0; PCresume = 0;
    PCimm = 0; PCrs1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_pc", PCaddress, 32'h0);
    chk("rst_state", {30'd0, PCstate}, 32'd0);
    chk("rst_count", PCcount, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", PCaddress, 32'(4 * i));
    end
    chk("seq_count", PCcount, 32'd5);
    chk("seq_plus4", PCplus4, 32'd24);
    chk("seq_state", {30'd0, PCstate}, 32'd0);
    PCjal = 1; PCimm = 32'hFFFF_FFFC; tick(); clr();
    chk("jal_back", PCaddress, 32'h10);
    PCbrTaken = 1; PCimm = 32'hFFFF_FFF8; tick(); clr();
    chk("br_back", PCaddress, 32'h08);
    PCjal = 1; PCjalr = 1; PCrs1 = 32'h101; PCimm = 32'h0F; tick(); clr();
    chk("jalr_prio", PCaddress, 32'h110);
    chk("jalr_count", PCcount, 32'd8);
    PCjalr = 1; PCrs1 = 32'h20; tick(); clr();
    chk("goto_20", PCaddress, 32'h20);
    PCjal = 1; PCimm = 32'd2; tick(); clr();
    chk("mis_state", {30'd0, PCstate}, 32'd2);
    chk("mis_cause", {30'd0, PCcause}, 32'd1);
    chk("mis_epc", PCepc, 32'h20);
    chk("mis_pc", PCaddress, 32'hFF0);
    chk("mis_count", PCcount, 32'd9);
    tick();
    chk("trap_hold", PCaddress, 32'hFF0);
    PCresume = 1; tick(); clr();
    chk("res_state", {30'd0, PCstate}, 32'd0);
    chk("res_pc", PCaddress, 32'h24);
    chk("res_cause", {30'd0, PCcause}, 32'd0);
    chk("res_epc", PCepc, 32'h20);
    PCjalr = 1; PCrs1 = 32'hFFC; tick(); clr();
    chk("goto_ffc", PCaddress, 32'hFFC);
    tick();
    chk("oor_state", {30'd0, PCstate}, 32'd2);
    chk("oor_cause", {30'd0, PCcause}, 32'd2);
    chk("oor_epc", PCepc, 32'hFFC);
    PCresume = 1; PChalt = 1; tick(); clr();
    chk("oor_res_state", {30'd0, PCstate}, 32'd2);
    chk("oor_res_cause", {30'd0, PCcause}, 32'd2);
    chk("oor_res_pc", PCaddress, 32'hFF0);
    #2 rst = 1;
    #1 chk("arst_trap_pc", PCaddress, 32'h0);
    chk("arst_trap_state", {30'd0, PCstate}, 32'd0);
    @(posedge clk); #1 rst = 0;
    repeat (7) tick();
    chk("seven_pc", PCaddress, 32'h1C);
    PCjal = 1; PCimm = 32'd2; tick(); clr();
    chk("t6_state", {30'd0, PCstate}, 32'd2);
    chk("t6_count", PCcount, 32'd7);
    #2 rst = 1;
    #1;
    chk("t6_pc", PCaddress, 32'h0);
    chk("t6_rstate", {30'd0, PCstate}, 32'd0);
    chk("t6_cause", {30'd0, PCcause}, 32'd0);
    chk("t6_epc", PCepc, 32'd0);
    chk("t6_rcount", PCcount, 32'd0);
    @(posedge clk); #1 rst = 0;
    PCjalr = 1; PCrs1 = 32'h40; tick(); clr();
    chk("goto_40", PCaddress, 32'h40);
    PCstall = 1; PCbrTaken = 1; PCimm = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", PCaddress, 32'h40);
      chk("stall_count", PCcount, 32'd1);
    end
    PChalt = 1; tick(); clr();
    chk("halt_state", {30'd0, PCstate}, 32'd1);
    chk("halt_pc", PCaddress, 32'h40);
    PCjal = 1; PCimm = 32'h100; PChalt = 1; tick(); clr();
    chk("halt_ignore", PCaddress, 32'h40);
    PCresume = 1; tick(); clr();
    chk("unhalt_state", {30'd0, PCstate}, 32'd0);
    chk("unhalt_pc", PCaddress, 32'h40);
    tick();
    chk("after_halt", PCaddress, 32'h44);
    chk("after_count", PCcount, 32'd2);
    PCresume = 1; tick(); clr();
    chk("run_resume", PCaddress, 32'h48);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
